// File: rtl/block_fetch_2x2.sv
// Walks a source frame in 2x2 blocks, reads the four pixels of each block through a
// 1-cycle-latency RAM port and presents them with the destination index to the averager.
module block_fetch_2x2 #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        val00,
  output logic [7:0]        val01,
  output logic [7:0]        val10,
  output logic [7:0]        val11,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [ADDR_W-1:0] dst_addr
);

  if ((SRC_W % 2 != 0) || (SRC_H % 2 != 0)) begin : g_bad_dims
    $error("block_fetch_2x2: SRC_W and SRC_H must be even");
  end
  if ((64'd1 << ADDR_W) < 64'(SRC_W * SRC_H)) begin : g_bad_addr
    $error("block_fetch_2x2: ADDR_W too narrow for SRC_W*SRC_H");
  end

  localparam logic [ADDR_W-1:0] BX_LAST = ADDR_W'(SRC_W / 2 - 1);
  localparam logic [ADDR_W-1:0] BY_LAST = ADDR_W'(SRC_H / 2 - 1);
  localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(SRC_W);

  typedef enum logic [2:0] {
    S_IDLE, S_R00, S_R01, S_R10, S_R11, S_CAP, S_HOLD, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, bx, by;
  logic              last_blk;

  assign last_blk = (bx == BX_LAST) && (by == BY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Block handshake: a block transfers on a rising edge where blk_valid & blk_ready are
  // both 1; blk_valid never drops and val*/dst_addr never change until that edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_R00;
      S_R00:   state_nxt = S_R01;
      S_R01:   state_nxt = S_R10;
      S_R10:   state_nxt = S_R11;
      S_R11:   state_nxt = S_CAP;
      S_CAP:   state_nxt = S_HOLD;
      S_HOLD:  if (blk_ready) state_nxt = last_blk ? S_FIN : S_R00;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      S_R00:   begin rd_en = 1'b1; rd_addr = base;                     end
      S_R01:   begin rd_en = 1'b1; rd_addr = base + ADDR_W'(1);        end
      S_R10:   begin rd_en = 1'b1; rd_addr = base + ROW;               end
      S_R11:   begin rd_en = 1'b1; rd_addr = base + ROW + ADDR_W'(1);  end
      default: ;
    endcase
    busy      = (state != S_IDLE) && (state != S_FIN);
    done      = (state == S_FIN);
    blk_valid = (state == S_HOLD);
  end

  // Each capture lands one state after its read, matching the RAM's 1-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      bx       <= '0;
      by       <= '0;
      dst_addr <= '0;
      val00    <= '0;
      val01    <= '0;
      val10    <= '0;
      val11    <= '0;
    end else begin
      case (state)
        S_R01:   val00 <= rd_data;
        S_R10:   val01 <= rd_data;
        S_R11:   val10 <= rd_data;
        S_CAP:   val11 <= rd_data;
        default: ;
      endcase
      if (state == S_IDLE && start) begin
        base     <= '0;
        bx       <= '0;
        by       <= '0;
        dst_addr <= '0;
      end else if (state == S_HOLD && blk_ready && !last_blk) begin
        dst_addr <= dst_addr + ADDR_W'(1);
        if (bx == BX_LAST) begin
          bx   <= '0;
          by   <= by + ADDR_W'(1);
          base <= base + ROW + ADDR_W'(2);
        end else begin
          bx   <= bx + ADDR_W'(1);
          base <= base + ADDR_W'(2);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_fetch_2x2.sv
// Randomized scoreboard bench for block_fetch_2x2 on a 4x4 frame with a 1-cycle RAM model.
module tb_block_fetch_2x2;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int AW = 15;
  localparam int BW = AW + 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          blk_ready = 1'b0;
  logic [7:0]    rd_data = 8'd0;
  logic          busy, done, rd_en, blk_valid;
  logic [AW-1:0] rd_addr, dst_addr;
  logic [7:0]    val00, val01, val10, val11;

  block_fetch_2x2 #(.SRC_W(SW), .SRC_H(SH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .val00(val00), .val01(val01), .val10(val10), .val11(val11),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .dst_addr(dst_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:SW*SH-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

  logic [AW-1:0] exp_rd[$];
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one frame pass is every 2x2 block in raster order.
  function automatic void push_pass();
    for (int by = 0; by < SH / 2; by++)
      for (int bx = 0; bx < SW / 2; bx++) begin
        int b;
        b = 2 * by * SW + 2 * bx;
        exp_rd.push_back(AW'(b));
        exp_rd.push_back(AW'(b + 1));
        exp_rd.push_back(AW'(b + SW));
        exp_rd.push_back(AW'(b + SW + 1));
        exp_q.push_back({AW'(by * (SW / 2) + bx), mem[b], mem[b+1], mem[b+SW], mem[b+SW+1]});
      end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (exp_rd.size() == 0) check("unexpected_read", 64'(rd_addr), 64'hFFFF_FFFF);
        else check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
      end
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) check("unexpected_block", 64'(dst_addr), 64'hFFFF_FFFF);
        else check("block", 64'({dst_addr, val00, val01, val10, val11}), 64'(exp_q.pop_front()));
      end
      if (done) begin
        n_done++;
        check("done_drained", 64'(exp_q.size() + exp_rd.size()), 64'(0));
      end
    end
  end

  task automatic start_pass();
    @(posedge clk);
    #1 start = 1'b1;
    push_pass();
    exp_done++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // sel: 0 rd_en, 1 blk_valid, 2 done, 3 read of address addr
  task automatic wait_for(input int sel, input logic [AW-1:0] addr, input int budget,
                          input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = rd_en;
        1:       hit = blk_valid;
        2:       hit = done;
        default: hit = rd_en && (rd_addr == addr);
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL timeout_%s: got no event within %0d cycles expected event", name, budget);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({busy, done, rd_en, blk_valid, rd_addr, dst_addr}), 64'(0));
    check({name, "_vals"}, 64'({val00, val01, val10, val11}), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, sum;
    bit seen;
    for (int i = 0; i < SW * SH; i++) mem[i] = 8'(i * 10);

    // Reset values
    repeat (3) @(posedge clk);
    check_zero("in_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_zero("after_reset");
    end

    // First block and full pass with blk_ready held high
    blk_ready = 1'b1;
    start_pass();
    wait_for(0, '0, 10, "first_r00");
    t0 = cyc;
    wait_for(1, '0, 20, "first_valid");
    check("valid_latency", 64'(cyc - t0), 64'(5));
    sum = int'(val00) + int'(val01) + int'(val10) + int'(val11);
    check("avg_block0", 64'(sum / 4),
          64'((int'(mem[0]) + int'(mem[1]) + int'(mem[4]) + int'(mem[5])) / 4));
    wait_for(2, '0, 100, "done_full");
    check("done_latency", 64'(cyc - t0), 64'(24));
    @(negedge clk);
    check("idle_after_done", 64'({busy, done}), 64'(0));

    // Backpressure on block 1
    start_pass();
    wait_for(3, AW'(2), 50, "blk1_r00");
    blk_ready = 1'b0;
    wait_for(1, '0, 20, "blk1_valid");
    repeat (7) begin
      @(negedge clk);
      check("bp_hold", 64'({blk_valid, rd_en, dst_addr, val00, val01, val10, val11}),
            64'({1'b1, 1'b0, AW'(1), mem[2], mem[3], mem[6], mem[7]}));
    end
    @(posedge clk);
    #1 blk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_advance", 64'({rd_en, rd_addr}), 64'({1'b1, AW'(8)}));
    wait_for(2, '0, 100, "done_bp");

    // Start while busy, and start during FIN
    start_pass();
    wait_for(3, AW'(4), 50, "blk0_r10");
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_for(2, '0, 100, "done_busy_start");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("fin_start_ignored", 64'({busy, rd_en}), 64'(0));
    start_pass();
    wait_for(2, '0, 100, "done_restart");

    // Mid-pass reset during R10 of block 2
    start_pass();
    wait_for(3, AW'(12), 100, "blk2_r10");
    #2 rst_n = 1'b0;
    exp_rd.delete();
    exp_q.delete();
    exp_done--;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_done_after_abort", 64'({done, busy}), 64'(0));
    end
    start_pass();
    wait_for(2, '0, 100, "done_replay");

    // Random frame contents with random backpressure
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < SW * SH; i++) mem[i] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      start_pass();
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
        @(posedge clk);
        #1 blk_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("rand_done", 64'(seen), 64'(1));
    end

    repeat (5) @(negedge clk);
    check("done_count", 64'(n_done), 64'(exp_done));
    check("queues_empty", 64'(exp_rd.size() + exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
